// File: rtl/outer_stream_adapter_pkg.sv
// Shared definitions for outer_stream_adapter: default widths, the length value
// that selects automatic (hub-terminated) jobs, the command layout and the job FSM states.
package outer_stream_adapter_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned LEN_W_DEF  = 15;

  // A command length of AUTO_LEN means "run until the hub flags last".
  localparam int unsigned AUTO_LEN   = 0;

  // Command word as it sits in the command queue (length only).
  typedef struct packed {
    logic [LEN_W_DEF-1:0] len;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNTED = 2'd1,
    ST_AUTO    = 2'd2
  } job_state_e;

  // True when a queued length selects automatic mode.
  function automatic logic is_auto_len(input logic [LEN_W_DEF-1:0] len);
    return len == LEN_W_DEF'(AUTO_LEN);
  endfunction

endpackage

// File: rtl/outer_stream_adapter_if.sv
// Handshake bundle of outer_stream_adapter: command port, hub (busSwitch) port
// and outer stream port.
//   master : environment side (drives commands, hub beats, outer ready)
//   slave  : adapter side
interface outer_stream_adapter_if
  import outer_stream_adapter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
);

  logic [LEN_W-1:0]  cmd;
  logic              cmd_isReady;
  logic              cmd_canReceive;

  logic [DATA_W-1:0] h_data;
  logic              h_isReady;
  logic              h_canReceive;
  logic              h_isLast_in;
  logic              h_isLast_out;

  logic [DATA_W-1:0] o_data;
  logic              o_isReady;
  logic              o_canReceive;

  modport master (
    output cmd, cmd_isReady, h_data, h_isReady, h_isLast_out, o_canReceive,
    input  cmd_canReceive, h_canReceive, h_isLast_in, o_data, o_isReady
  );

  modport slave (
    input  cmd, cmd_isReady, h_data, h_isReady, h_isLast_out, o_canReceive,
    output cmd_canReceive, h_canReceive, h_isLast_in, o_data, o_isReady
  );

endinterface

// File: rtl/outer_stream_adapter_fifo.sv
// stream_fifo: synchronous FIFO with async active-low reset.
//   push/wdata : write request (ignored while full, even if a pop happens the same cycle)
//   pop        : read request (ignored while empty)
//   rdata      : head entry, 0 when empty
//   full/empty : occupancy flags derived from registered pointers
module stream_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Pointers carry one wrap bit to tell full from empty.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    rdata    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/outer_stream_adapter.sv
// outer_stream_adapter: bridges one busSwitch port to an outer stream.
// Each queued command runs a job that forwards either a fixed number of hub
// beats (counted) or beats until the hub flags last (auto). A data FIFO sits
// between hub and outer handshakes so there is no combinational o->h path.
//   clk, rst   : clock, async active-low reset
//   bus        : command / hub / outer handshakes (slave modport)
//   busy       : active job, queued command or buffered data
//   beats_left : remaining beats of a counted job, else 0
module outer_stream_adapter
  import outer_stream_adapter_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CMDQ_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  outer_stream_adapter_if.slave bus,
  output logic                 busy,
  output logic [LEN_W-1:0]     beats_left
);

  logic             cmdq_full, cmdq_empty, cmdq_pop;
  logic [LEN_W-1:0] cmdq_head;
  logic             fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  job_state_e       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  logic active, counted, h_can, h_beat, o_beat, job_end;

  stream_fifo #(.W(LEN_W), .DEPTH(CMDQ_DEPTH)) u_cmdq (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.cmd_isReady),
    .wdata (bus.cmd),
    .pop   (cmdq_pop),
    .rdata (cmdq_head),
    .full  (cmdq_full),
    .empty (cmdq_empty)
  );

  stream_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (h_beat),
    .wdata (bus.h_data),
    .pop   (o_beat),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Job FSM: next state, remaining count and command pop.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    cmdq_pop = 1'b0;
    job_end  = 1'b0;

    active  = (state_q != ST_IDLE);
    counted = (state_q == ST_COUNTED);
    h_can   = active & ~fifo_full;
    h_beat  = bus.h_isReady & h_can;
    o_beat  = ~fifo_empty & bus.o_canReceive;

    case (state_q)
      ST_COUNTED: begin
        if (h_beat) begin
          if (rem_q == LEN_W'(1)) job_end = 1'b1;
          else                    rem_d   = rem_q - LEN_W'(1);
        end
      end
      ST_AUTO: begin
        if (h_beat && bus.h_isLast_out) job_end = 1'b1;
      end
      default: ;
    endcase

    if (job_end) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end

    // Load the next command on the job-ending edge so queued jobs run back-to-back.
    if ((!active || job_end) && !cmdq_empty) begin
      cmdq_pop = 1'b1;
      rem_d    = cmdq_head;
      state_d  = (cmdq_head == LEN_W'(AUTO_LEN)) ? ST_AUTO : ST_COUNTED;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Gated by rst so the port reads 0 while reset is held.
  assign bus.cmd_canReceive = rst & ~cmdq_full;
  assign bus.h_canReceive   = h_can;
  assign bus.h_isLast_in    = counted & (rem_q == LEN_W'(1));
  assign bus.o_data         = fifo_head;
  assign bus.o_isReady      = ~fifo_empty;
  assign busy               = active | ~cmdq_empty | ~fifo_empty;
  assign beats_left         = counted ? rem_q : '0;

endmodule

// File: tb/tb_outer_stream_adapter.sv
// Directed bench for outer_stream_adapter: counted/auto jobs, back-pressure,
// command queue full, back-to-back jobs, mid-job reset and length extremes.
module tb_outer_stream_adapter;

  localparam int unsigned DW = 64;
  localparam int unsigned LW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy;
  logic [LW-1:0] beats_left;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  outer_stream_adapter_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

  outer_stream_adapter #(
    .DATA_W(DW), .LEN_W(LW), .FIFO_DEPTH(4), .CMDQ_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .beats_left (beats_left)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Push one command into an empty queue; returns at the first active cycle.
  task automatic start_job(input logic [LW-1:0] len);
    bus.cmd         = len;
    bus.cmd_isReady = 1'b1;
    #1;
    chk("cmd_accept", 64'(bus.cmd_canReceive), 64'd1);
    nxt();
    bus.cmd_isReady = 1'b0;
    #1;
    chk("load_gap_hcan", 64'(bus.h_canReceive), 64'd0);
    nxt();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst              = 1'b0;
    bus.cmd          = '0;
    bus.cmd_isReady  = 1'b0;
    bus.h_data       = '0;
    bus.h_isReady    = 1'b0;
    bus.h_isLast_out = 1'b0;
    bus.o_canReceive = 1'b0;

    // Reset: everything 0 while held, cmd_canReceive=1 after release.
    #3;
    chk("rst_cmd_can", 64'(bus.cmd_canReceive), 64'd0);
    chk("rst_busy",    64'(busy),               64'd0);
    chk("rst_o_ready", 64'(bus.o_isReady),      64'd0);
    nxt(); nxt();
    rst = 1'b1;
    #1;
    chk("rel_cmd_can", 64'(bus.cmd_canReceive), 64'd1);
    chk("rel_h_can",   64'(bus.h_canReceive),   64'd0);
    chk("rel_bl",      64'(beats_left),         64'd0);
    chk("rel_busy",    64'(busy),               64'd0);
    nxt();

    // 1: counted job of 3, hub offers 5 beats.
    bus.o_canReceive = 1'b1;
    start_job(LW'(3));
    for (int i = 0; i < 5; i++) begin
      bus.h_isReady = 1'b1;
      bus.h_data    = 64'hD0 + 64'(i);
      #1;
      if (i < 3) begin
        chk("t1_hcan",   64'(bus.h_canReceive), 64'd1);
        chk("t1_bl",     64'(beats_left),       64'(3 - i));
        chk("t1_last",   64'(bus.h_isLast_in),  64'(i == 2));
      end else begin
        chk("t1_hcan_end", 64'(bus.h_canReceive), 64'd0);
        chk("t1_bl_end",   64'(beats_left),       64'd0);
      end
      if (i >= 1 && i <= 3) chk("t1_odata", bus.o_data, 64'hD0 + 64'(i - 1));
      if (i == 4) begin
        chk("t1_o_empty", 64'(bus.o_isReady), 64'd0);
        chk("t1_busy",    64'(busy),          64'd0);
      end
      nxt();
    end
    bus.h_isReady = 1'b0;

    // 2: auto job, hub flags last on the 4th beat.
    start_job(LW'(0));
    for (int k = 0; k < 5; k++) begin
      bus.h_isReady    = 1'b1;
      bus.h_data       = 64'hB0 + 64'(k);
      bus.h_isLast_out = (k == 3);
      #1;
      if (k < 4) begin
        chk("t2_hcan", 64'(bus.h_canReceive), 64'd1);
        chk("t2_last", 64'(bus.h_isLast_in),  64'd0);
        chk("t2_bl",   64'(beats_left),       64'd0);
      end else begin
        chk("t2_hcan_end", 64'(bus.h_canReceive), 64'd0);
        chk("t2_busy_buf", 64'(busy),             64'd1);
      end
      if (k >= 1) chk("t2_odata", bus.o_data, 64'hB0 + 64'(k - 1));
      nxt();
    end
    bus.h_isReady    = 1'b0;
    bus.h_isLast_out = 1'b0;
    #1;
    chk("t2_busy_end", 64'(busy), 64'd0);
    nxt();

    // 3: counted job of 8 with outer stalled, then released.
    bus.o_canReceive = 1'b0;
    start_job(LW'(8));
    for (int k = 0; k < 6; k++) begin
      bus.h_isReady = 1'b1;
      bus.h_data    = 64'hC0 + 64'((k < 4) ? k : 4);
      #1;
      chk("t3_hcan", 64'(bus.h_canReceive), 64'(k < 4));
      chk("t3_bl",   64'(beats_left),       64'((k < 4) ? 8 - k : 4));
      if (k >= 4) chk("t3_head", bus.o_data, 64'hC0);
      nxt();
    end
    for (int r = 0; r < 9; r++) begin
      bus.o_canReceive = 1'b1;
      bus.h_isReady    = (r >= 1 && r <= 4);
      bus.h_data       = 64'hC0 + 64'(3 + r);
      #1;
      chk("t3_odata", bus.o_data,                64'((r < 8) ? 64'hC0 + 64'(r) : 64'h0));
      chk("t3_ordy",  64'(bus.o_isReady),        64'(r < 8));
      chk("t3_hcan2", 64'(bus.h_canReceive),     64'(r >= 1 && r <= 4));
      if (r >= 1 && r <= 4) begin
        chk("t3_bl2",   64'(beats_left),      64'(5 - r));
        chk("t3_last",  64'(bus.h_isLast_in), 64'(r == 4));
      end
      if (r == 8) chk("t3_busy", 64'(busy), 64'd0);
      nxt();
    end
    bus.h_isReady = 1'b0;

    // 4: queue fills, extra command ignored, jobs run back-to-back.
    bus.cmd = LW'(2); bus.cmd_isReady = 1'b1; #1;
    chk("t4_can0", 64'(bus.cmd_canReceive), 64'd1);
    nxt();
    bus.cmd = LW'(1); #1;
    chk("t4_can1", 64'(bus.cmd_canReceive), 64'd1);
    nxt();
    bus.cmd = LW'(1); #1;
    chk("t4_can2", 64'(bus.cmd_canReceive), 64'd1);
    chk("t4_bl2",  64'(beats_left),         64'd2);
    nxt();
    bus.cmd = LW'(5); bus.h_isReady = 1'b1; bus.h_data = 64'hE0; #1;
    chk("t4_full",  64'(bus.cmd_canReceive), 64'd0);
    chk("t4_hcan3", 64'(bus.h_canReceive),   64'd1);
    chk("t4_last3", 64'(bus.h_isLast_in),    64'd0);
    nxt();
    bus.h_data = 64'hE1; #1;
    chk("t4_full4", 64'(bus.cmd_canReceive), 64'd0);
    chk("t4_bl4",   64'(beats_left),         64'd1);
    chk("t4_last4", 64'(bus.h_isLast_in),    64'd1);
    chk("t4_od4",   bus.o_data,              64'hE0);
    nxt();
    bus.cmd_isReady = 1'b0; bus.h_data = 64'hE2; #1;
    chk("t4_can5",  64'(bus.cmd_canReceive), 64'd1);
    chk("t4_hcan5", 64'(bus.h_canReceive),   64'd1);
    chk("t4_last5", 64'(bus.h_isLast_in),    64'd1);
    chk("t4_od5",   bus.o_data,              64'hE1);
    nxt();
    bus.h_data = 64'hE3; #1;
    chk("t4_hcan6", 64'(bus.h_canReceive), 64'd1);
    chk("t4_last6", 64'(bus.h_isLast_in),  64'd1);
    chk("t4_od6",   bus.o_data,            64'hE2);
    nxt();
    bus.h_isReady = 1'b0; #1;
    chk("t4_hcan7", 64'(bus.h_canReceive), 64'd0);
    chk("t4_bl7",   64'(beats_left),       64'd0);
    chk("t4_od7",   bus.o_data,            64'hE3);
    nxt();
    #1;
    chk("t4_busy", 64'(busy), 64'd0);

    // 5: reset in the middle of a counted job.
    bus.o_canReceive = 1'b0;
    start_job(LW'(10));
    for (int k = 0; k < 3; k++) begin
      bus.h_isReady = 1'b1;
      bus.h_data    = 64'hF0 + 64'(k);
      #1;
      chk("t5_bl", 64'(beats_left), 64'(10 - k));
      nxt();
    end
    bus.h_isReady = 1'b0; #1;
    chk("t5_bl7", 64'(beats_left), 64'd7);
    rst = 1'b0; #1;
    chk("t5_r_cmdcan", 64'(bus.cmd_canReceive), 64'd0);
    chk("t5_r_hcan",   64'(bus.h_canReceive),   64'd0);
    chk("t5_r_last",   64'(bus.h_isLast_in),    64'd0);
    chk("t5_r_ordy",   64'(bus.o_isReady),      64'd0);
    chk("t5_r_odata",  bus.o_data,              64'd0);
    chk("t5_r_busy",   64'(busy),               64'd0);
    chk("t5_r_bl",     64'(beats_left),         64'd0);
    nxt();
    rst = 1'b1; #1;
    chk("t5_cmdcan", 64'(bus.cmd_canReceive), 64'd1);
    chk("t5_busy",   64'(busy),               64'd0);
    chk("t5_bl0",    64'(beats_left),         64'd0);
    chk("t5_ordy",   64'(bus.o_isReady),      64'd0);
    nxt();

    // 6: single-beat job, then maximum-length job.
    bus.o_canReceive = 1'b1;
    start_job(LW'(1));
    bus.h_isReady = 1'b1; bus.h_data = 64'h66; #1;
    chk("t6_hcan", 64'(bus.h_canReceive), 64'd1);
    chk("t6_last", 64'(bus.h_isLast_in),  64'd1);
    chk("t6_bl",   64'(beats_left),       64'd1);
    nxt();
    bus.h_isReady = 1'b0; #1;
    chk("t6_hcan_end", 64'(bus.h_canReceive), 64'd0);
    chk("t6_odata",    bus.o_data,            64'h66);
    nxt();
    #1;
    chk("t6_busy", 64'(busy), 64'd0);

    start_job(LW'(32767));
    bad = 0;
    for (int n = 0; n < 32767; n++) begin
      bus.h_isReady = 1'b1;
      bus.h_data    = 64'(n);
      #1;
      if (beats_left != LW'(32767 - n) || !bus.h_canReceive) bad++;
      if (n == 0)     chk("t6_max_bl0",  64'(beats_left),      64'd32767);
      if (n == 32765) chk("t6_max_nl",   64'(bus.h_isLast_in), 64'd0);
      if (n == 32766) chk("t6_max_last", 64'(bus.h_isLast_in), 64'd1);
      nxt();
    end
    bus.h_isReady = 1'b0; #1;
    chk("t6_max_trace", 64'(bad),              64'd0);
    chk("t6_max_bl",    64'(beats_left),       64'd0);
    chk("t6_max_hcan",  64'(bus.h_canReceive), 64'd0);
    nxt();
    #1;
    chk("t6_max_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
